// File: rtl/op_dispatch_if.sv
// ============================================================================
// op_dispatch_if : FIFO-side and compute-unit-side bus of the op dispatcher
// Rev 1.0
// ============================================================================
`default_nettype none

interface op_dispatch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 3,
  parameter int RES_WIDTH  = 4
);
  logic                  op_pkt_available;
  logic [DATA_WIDTH-1:0] in_fifo_data_i;
  logic [NUM_MODES-1:0]  in_fifo_mode_i;
  logic [RES_WIDTH-1:0]  in_fifo_res_i;
  logic                  fifo_pop;
  logic [NUM_MODES-1:0]  unit_ready;
  logic [NUM_MODES-1:0]  unit_valid;
  logic [DATA_WIDTH-1:0] unit_data;
  logic [RES_WIDTH-1:0]  unit_res;

  // master is the dispatcher; slave is the FIFO plus compute units around it
  modport master (
    input  op_pkt_available, in_fifo_data_i, in_fifo_mode_i, in_fifo_res_i, unit_ready,
    output fifo_pop, unit_valid, unit_data, unit_res
  );

  modport slave (
    output op_pkt_available, in_fifo_data_i, in_fifo_mode_i, in_fifo_res_i, unit_ready,
    input  fifo_pop, unit_valid, unit_data, unit_res
  );
endinterface

`default_nettype wire

// File: rtl/op_dispatch.sv
// ============================================================================
// op_dispatch : pops op packets, routes them to one-hot selected compute unit
// Rev 1.0
// ============================================================================
`default_nettype none

module op_dispatch #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 3,
  parameter int RES_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  op_dispatch_if.master        bus,
  output logic                 mode_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] disp_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    CAPTURE  = 3'd2,
    DISPATCH = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_MODES-1:0]  mode_q;
  logic [RES_WIDTH-1:0]  res_q;
  logic [CNT_WIDTH-1:0]  disp_cnt_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic                  mode_onehot;
  logic                  handshake;

  assign mode_onehot = ($countones(bus.in_fifo_mode_i) == 1);
  // Only the ready bit of the selected unit can complete the handoff
  assign handshake   = (state_q == DISPATCH) && ((mode_q & bus.unit_ready) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.fifo_pop   = 1'b0;
    bus.unit_valid = '0;
    mode_err       = 1'b0;
    busy           = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.op_pkt_available) state_d = FETCH;
      end
      FETCH: begin
        bus.fifo_pop = 1'b1;
        state_d      = CAPTURE;
      end
      CAPTURE: begin
        state_d = mode_onehot ? DISPATCH : ERR;
      end
      DISPATCH: begin
        bus.unit_valid = mode_q;
        if (handshake) state_d = bus.op_pkt_available ? FETCH : IDLE;
      end
      ERR: begin
        mode_err = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO head is valid one cycle after the pop, i.e. during CAPTURE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= '0;
      res_q  <= '0;
    end else if (state_q == CAPTURE) begin
      data_q <= bus.in_fifo_data_i;
      mode_q <= bus.in_fifo_mode_i;
      res_q  <= bus.in_fifo_res_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (handshake && (disp_cnt_q != '1)) disp_cnt_q <= disp_cnt_q + C_CNT_ONE;
      if ((state_q == ERR) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + C_CNT_ONE;
    end
  end

  assign bus.unit_data = data_q;
  assign bus.unit_res  = res_q;
  assign disp_cnt      = disp_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_op_dispatch.sv
// ============================================================================
// tb_op_dispatch : directed and random checks of op_dispatch against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_op_dispatch;

  localparam int DW   = 32;
  localparam int NM   = 3;
  localparam int RW   = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [NM-1:0] mode;
    logic [RW-1:0] res;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode_err;
  logic          busy;
  logic [CW-1:0] disp_cnt;
  logic [CW-1:0] err_cnt;

  op_dispatch_if #(.DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW)) bus ();

  op_dispatch #(.DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mode_err (mode_err),
    .busy     (busy),
    .disp_cnt (disp_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rand_en = 1'b0;
  pkt_t fifo_q[$];

  // Reference model: age counts cycles since the pop strobe, -1 when idle
  int   m_age  = -1;
  pkt_t m_pkt  = '{default: '0};
  pkt_t m_hold = '{default: '0};
  int   m_disp = 0;
  int   m_err  = 0;

  // Observations used by the directed scenarios
  int   n_err_pulse, n_valid_cyc, n_pop;
  int   pop_cyc[$];
  int   hs_tags[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [NM-1:0] m);
    return $countones(m) == 1;
  endfunction

  task automatic clear_obs();
    n_err_pulse = 0; n_valid_cyc = 0; n_pop = 0;
    pop_cyc.delete(); hs_tags.delete();
  endtask

  task automatic model_reset();
    m_age = -1; m_pkt = '{default: '0}; m_hold = '{default: '0};
    m_disp = 0; m_err = 0;
  endtask

  // Inputs are final here; the upcoming posedge samples exactly these values
  task automatic advance();
    if ((bus.unit_valid & bus.unit_ready) != '0) hs_tags.push_back(int'(bus.unit_res));
    if (m_age < 0) begin
      if (bus.op_pkt_available) m_age = 0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (m_age == 1) begin
      m_pkt.data = bus.in_fifo_data_i;
      m_pkt.mode = bus.in_fifo_mode_i;
      m_pkt.res  = bus.in_fifo_res_i;
      m_hold     = m_pkt;
      m_age      = 2;
    end else if (!legal(m_pkt.mode)) begin
      if (m_err < MAXC) m_err++;
      m_age = -1;
    end else if ((bus.unit_ready & m_pkt.mode) != '0) begin
      if (m_disp < MAXC) m_disp++;
      m_age = bus.op_pkt_available ? 0 : -1;
    end else begin
      m_age++;
    end
  endtask

  task automatic compare();
    bit ok = legal(m_pkt.mode);
    chk("fifo_pop",   64'(bus.fifo_pop),   64'(m_age == 0));
    chk("busy",       64'(busy),           64'(m_age >= 0));
    chk("unit_valid", 64'(bus.unit_valid), 64'((m_age >= 2 && ok) ? m_pkt.mode : 3'b000));
    chk("mode_err",   64'(mode_err),       64'(m_age == 2 && !ok));
    chk("unit_data",  64'(bus.unit_data),  64'(m_hold.data));
    chk("unit_res",   64'(bus.unit_res),   64'(m_hold.res));
    chk("disp_cnt",   64'(disp_cnt),       64'(m_disp));
    chk("err_cnt",    64'(err_cnt),        64'(m_err));
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.data = $urandom;
    p.res  = RW'($urandom);
    if ($urandom_range(0, 9) < 8) p.mode = NM'(1 << $urandom_range(0, NM - 1));
    else                          p.mode = NM'($urandom);
    return p;
  endfunction

  task automatic cycle();
    pkt_t p;
    advance();
    @(negedge clk);
    cyc++;
    compare();
    if (mode_err) n_err_pulse++;
    if (bus.unit_valid != '0) n_valid_cyc++;
    if (bus.fifo_pop) begin
      n_pop++;
      pop_cyc.push_back(cyc);
      if (fifo_q.size() > 0) begin
        p = fifo_q.pop_front();
        bus.in_fifo_data_i = p.data;
        bus.in_fifo_mode_i = p.mode;
        bus.in_fifo_res_i  = p.res;
      end
    end
    if (rand_en) begin
      if ($urandom_range(0, 3) == 0) fifo_q.push_back(rand_pkt());
      bus.unit_ready = NM'($urandom);
    end
    bus.op_pkt_available = (fifo_q.size() != 0);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [NM-1:0] m, input logic [RW-1:0] r);
    pkt_t p;
    p.data = d; p.mode = m; p.res = r;
    fifo_q.push_back(p);
    bus.op_pkt_available = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_q.delete();
    bus.op_pkt_available = 1'b0;
    bus.unit_ready = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_fifo_pop",   64'(bus.fifo_pop),   64'(0));
    chk("rst_unit_valid", 64'(bus.unit_valid), 64'(0));
    chk("rst_unit_data",  64'(bus.unit_data),  64'(0));
    chk("rst_busy",       64'(busy),           64'(0));
    chk("rst_disp_cnt",   64'(disp_cnt),       64'(0));
    chk("rst_err_cnt",    64'(err_cnt),        64'(0));
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    bus.op_pkt_available = 1'b0;
    bus.in_fifo_data_i   = '0;
    bus.in_fifo_mode_i   = '0;
    bus.in_fifo_res_i    = '0;
    bus.unit_ready       = '0;
    clear_obs();

    // Single dispatch with hand-computed timing
    do_reset();
    bus.unit_ready = 3'b111;
    push(32'hDEADBEEF, 3'b010, 4'h5);
    cycle(); chk("single_pop_T1",   64'(bus.fifo_pop),   64'(1));
    cycle(); chk("single_nopop_T2", 64'(bus.fifo_pop),   64'(0));
    cycle(); chk("single_valid_T3", 64'(bus.unit_valid), 64'(3'b010));
    chk("single_data_T3", 64'(bus.unit_data), 64'(32'hDEADBEEF));
    chk("single_res_T3",  64'(bus.unit_res),  64'(4'h5));
    cycle(); chk("single_disp_cnt", 64'(disp_cnt), 64'(1));
    chk("single_idle", 64'(busy), 64'(0));

    // Backpressure on unit 2 for ten cycles
    do_reset();
    bus.unit_ready = 3'b011;
    push(32'hA5A5_0F0F, 3'b100, 4'h3);
    for (int i = 0; i < 10 && bus.unit_valid == '0; i++) cycle();
    chk("bp_valid_reached", 64'(bus.unit_valid), 64'(3'b100));
    n_valid_cyc = 0; n_pop = 0;
    repeat (10) cycle();
    chk("bp_valid_held", 64'(n_valid_cyc), 64'(10));
    chk("bp_no_pop",     64'(n_pop),       64'(0));
    chk("bp_data_held",  64'(bus.unit_data), 64'(32'hA5A5_0F0F));
    bus.unit_ready = 3'b111;
    cycle(); chk("bp_disp_cnt", 64'(disp_cnt), 64'(1));

    // Asynchronous reset while stuck in DISPATCH with nonzero counters
    bus.unit_ready = 3'b000;
    push(32'h1234_5678, 3'b001, 4'h9);
    repeat (5) cycle();
    chk("ar_pre_valid", 64'(bus.unit_valid), 64'(3'b001));
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.unit_valid), 64'(0));
    chk("ar_busy",  64'(busy),           64'(0));
    chk("ar_disp",  64'(disp_cnt),       64'(0));
    chk("ar_data",  64'(bus.unit_data),  64'(0));
    fifo_q.delete();
    bus.op_pkt_available = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (4) cycle();
    chk("ar_no_pop_after", 64'(n_pop), 64'(0));

    // Illegal modes
    do_reset();
    bus.unit_ready = 3'b111;
    push(32'h0000_0001, 3'b000, 4'h1);
    push(32'h0000_0002, 3'b011, 4'h2);
    repeat (10) cycle();
    chk("ill_err_pulses", 64'(n_err_pulse), 64'(2));
    chk("ill_err_cnt",    64'(err_cnt),     64'(2));
    chk("ill_disp_cnt",   64'(disp_cnt),    64'(0));
    chk("ill_no_valid",   64'(n_valid_cyc), 64'(0));

    // Streaming: eight preloaded packets, units always ready
    do_reset();
    bus.unit_ready = 3'b111;
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i), NM'(1 << (i % 3)), RW'(i));
    repeat (30) cycle();
    chk("str_pops", 64'(pop_cyc.size()), 64'(8));
    if (pop_cyc.size() == 8) chk("str_pop_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'(21));
    chk("str_hs", 64'(hs_tags.size()), 64'(8));
    for (int i = 0; i < hs_tags.size(); i++) chk("str_tag_order", 64'(hs_tags[i]), 64'(i));
    chk("str_disp_cnt", 64'(disp_cnt), 64'(8));

    // Saturation at 4 bits
    do_reset();
    bus.unit_ready = 3'b111;
    for (int i = 0; i < 20; i++) push($urandom, NM'(1 << (i % 3)), RW'(i));
    repeat (70) cycle();
    chk("sat_hs", 64'(hs_tags.size()), 64'(20));
    chk("sat_disp_cnt", 64'(disp_cnt), 64'(4'hF));

    // Random traffic with random backpressure and illegal modes
    for (int r = 0; r < 4; r++) begin
      do_reset();
      rand_en = 1'b1;
      repeat (500) cycle();
      rand_en = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
